// File: rtl/uart_rx_word_if.sv
// Bundle of the serial line and the word-level result of uart_rx_word.
// The master side is the receiver; the slave side is whoever drives the
// line and consumes the recovered words.
`timescale 1ns/1ps
interface uart_rx_word_if;
   logic        rx;
   logic [31:0] data;
   logic        data_valid;
   logic        frame_err;
   logic        sync_err;

   modport master (
      input  rx,
      output data,
      output data_valid,
      output frame_err,
      output sync_err
   );

   modport slave (
      output rx,
      input  data,
      input  data_valid,
      input  frame_err,
      input  sync_err
   );
endinterface

// File: rtl/uart_rx_word.sv
// UART word receiver: 11-bit frames (start, 8 data LSB first, zero check
// bit, stop) assembled into 32-bit words framed as 4 data bytes + 0x0A 0x0D.
// A bit FSM recovers bytes; a packet FSM tracks byte position and resyncs
// by hunting for the 0x0A 0x0D trailer after any error.
`timescale 1ns/1ps
module uart_rx_word #(
   parameter int BPS   = 868,
   parameter int BPS_2 = 434
) (
   input  logic           clk,
   input  logic           rst_n,
   uart_rx_word_if.master bus
);

   localparam int             CW      = $clog2(BPS + 1);
   localparam logic [CW-1:0]  FULL_C  = CW'(BPS);
   localparam logic [CW-1:0]  HALF_C  = CW'(BPS_2 - 1);
   localparam logic [7:0]     LF_BYTE = 8'h0A;
   localparam logic [7:0]     CR_BYTE = 8'h0D;

   typedef enum logic [2:0] {
      BIT_IDLE  = 3'd0,
      BIT_START = 3'd1,
      BIT_DATA  = 3'd2,
      BIT_CHECK = 3'd3,
      BIT_STOP  = 3'd4
   } bit_state_t;

   typedef enum logic [2:0] {
      PK_B0      = 3'd0,
      PK_B1      = 3'd1,
      PK_B2      = 3'd2,
      PK_B3      = 3'd3,
      PK_LF      = 3'd4,
      PK_CR      = 3'd5,
      PK_HUNT    = 3'd6,
      PK_HUNT_CR = 3'd7
   } pk_state_t;

   // A frame is acceptable only with a zero check bit and a high stop bit.
   function automatic logic frame_ok(input logic check_bit, input logic stop_bit);
      return (check_bit == 1'b0) && (stop_bit == 1'b1);
   endfunction

   logic          rx_meta_r;
   logic          rx_sync_r;
   logic          rx_prev_r;
   logic [1:0]    fill_r;
   logic          edge_s;

   bit_state_t    bit_state_r;
   logic [CW-1:0] cnt_r;
   logic [2:0]    bit_cnt_r;
   logic [7:0]    byte_sr_r;
   logic          check_r;
   logic          tick_s;
   logic          frame_done_s;
   logic          frame_good_s;
   logic          frame_bad_s;

   pk_state_t     pk_state_r;
   logic [31:0]   staging_r;
   logic [31:0]   data_r;
   logic          data_valid_r;
   logic          frame_err_r;
   logic          sync_err_r;

   // Two-stage synchronizer plus previous-sample register for edge detection;
   // fill_r blocks edge detection until the chain holds real line samples,
   // so a line already low at reset release is not taken as a start.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta_r <= 1'b1;
         rx_sync_r <= 1'b1;
         rx_prev_r <= 1'b1;
         fill_r    <= 2'd0;
      end else begin
         rx_meta_r <= bus.rx;
         rx_sync_r <= rx_meta_r;
         rx_prev_r <= rx_sync_r;
         if (fill_r != 2'd3) begin
            fill_r <= fill_r + 2'd1;
         end else begin
            fill_r <= fill_r;
         end
      end
   end

   assign edge_s = (fill_r == 2'd3) && rx_prev_r && !rx_sync_r;

   // Sample strobe: half a bit after the start edge, then once per bit period.
   always_comb begin
      tick_s = 1'b0;
      if (bit_state_r == BIT_START) begin
         tick_s = (cnt_r == HALF_C);
      end else begin
         tick_s = (cnt_r == FULL_C);
      end
   end

   assign frame_done_s = (bit_state_r == BIT_STOP) && tick_s;
   assign frame_good_s = frame_done_s && frame_ok(check_r, rx_sync_r);
   assign frame_bad_s  = frame_done_s && !frame_ok(check_r, rx_sync_r);

   // Bit FSM: baud counter runs only while a frame is in progress and
   // restarts on every start edge, so timing error cannot accumulate.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bit_state_r <= BIT_IDLE;
         cnt_r       <= '0;
         bit_cnt_r   <= 3'd0;
         byte_sr_r   <= 8'd0;
         check_r     <= 1'b0;
      end else begin
         case (bit_state_r)
            BIT_IDLE: begin
               cnt_r <= '0;
               if (edge_s) begin
                  bit_cnt_r   <= 3'd0;
                  bit_state_r <= BIT_START;
               end else begin
                  bit_state_r <= BIT_IDLE;
               end
            end
            BIT_START: begin
               if (tick_s) begin
                  cnt_r <= '0;
                  // A line back high at mid-start was only a glitch.
                  bit_state_r <= rx_sync_r ? BIT_IDLE : BIT_DATA;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            BIT_DATA: begin
               if (tick_s) begin
                  cnt_r     <= '0;
                  byte_sr_r <= {rx_sync_r, byte_sr_r[7:1]};
                  bit_cnt_r <= bit_cnt_r + 3'd1;
                  if (bit_cnt_r == 3'd7) begin
                     bit_state_r <= BIT_CHECK;
                  end else begin
                     bit_state_r <= BIT_DATA;
                  end
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            BIT_CHECK: begin
               if (tick_s) begin
                  cnt_r       <= '0;
                  check_r     <= rx_sync_r;
                  bit_state_r <= BIT_STOP;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            BIT_STOP: begin
               // Leave at mid-stop so a back-to-back start edge is not missed.
               if (tick_s) begin
                  cnt_r       <= '0;
                  bit_state_r <= BIT_IDLE;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            default: begin
               cnt_r       <= '0;
               bit_state_r <= BIT_IDLE;
            end
         endcase
      end
   end

   // Packet FSM: places bytes into the staging word, checks the trailer,
   // and publishes the whole word at once; hunts for 0A 0D after any error.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pk_state_r   <= PK_B0;
         staging_r    <= 32'd0;
         data_r       <= 32'd0;
         data_valid_r <= 1'b0;
         frame_err_r  <= 1'b0;
         sync_err_r   <= 1'b0;
      end else begin
         data_valid_r <= 1'b0;
         frame_err_r  <= 1'b0;
         sync_err_r   <= 1'b0;
         if (frame_bad_s) begin
            frame_err_r <= 1'b1;
            pk_state_r  <= PK_HUNT;
         end else if (frame_good_s) begin
            case (pk_state_r)
               PK_B0: begin
                  staging_r[7:0] <= byte_sr_r;
                  pk_state_r     <= PK_B1;
               end
               PK_B1: begin
                  staging_r[15:8] <= byte_sr_r;
                  pk_state_r      <= PK_B2;
               end
               PK_B2: begin
                  staging_r[23:16] <= byte_sr_r;
                  pk_state_r       <= PK_B3;
               end
               PK_B3: begin
                  staging_r[31:24] <= byte_sr_r;
                  pk_state_r       <= PK_LF;
               end
               PK_LF: begin
                  if (byte_sr_r == LF_BYTE) begin
                     pk_state_r <= PK_CR;
                  end else begin
                     sync_err_r <= 1'b1;
                     pk_state_r <= PK_HUNT;
                  end
               end
               PK_CR: begin
                  if (byte_sr_r == CR_BYTE) begin
                     data_r       <= staging_r;
                     data_valid_r <= 1'b1;
                     pk_state_r   <= PK_B0;
                  end else begin
                     sync_err_r <= 1'b1;
                     pk_state_r <= PK_HUNT;
                  end
               end
               PK_HUNT: begin
                  if (byte_sr_r == LF_BYTE) begin
                     pk_state_r <= PK_HUNT_CR;
                  end else begin
                     pk_state_r <= PK_HUNT;
                  end
               end
               PK_HUNT_CR: begin
                  if (byte_sr_r == CR_BYTE) begin
                     pk_state_r <= PK_B0;
                  end else if (byte_sr_r == LF_BYTE) begin
                     pk_state_r <= PK_HUNT_CR;
                  end else begin
                     pk_state_r <= PK_HUNT;
                  end
               end
               default: begin
                  pk_state_r <= PK_HUNT;
               end
            endcase
         end else begin
            pk_state_r <= pk_state_r;
         end
      end
   end

   assign bus.data       = data_r;
   assign bus.data_valid = data_valid_r;
   assign bus.frame_err  = frame_err_r;
   assign bus.sync_err   = sync_err_r;

endmodule

// File: tb/tb_uart_rx_word.sv
// Bench for uart_rx_word: drives serial frames at chosen bit periods and
// compares the observed pulse stream against a byte-stream reference model.
`timescale 1ns/1ps
module tb_uart_rx_word;

   localparam int BPS   = 33;
   localparam int BPS_2 = 16;
   localparam int BIT   = BPS + 1;          // nominal bit period, 34 clocks
   localparam int FAST  = 33;               // sender clock +3% -> shorter bits
   localparam int SLOW  = 35;               // sender clock -3% -> longer bits
   localparam int LAT   = 3 + BPS_2 + 10 * BIT; // start drive to pulse visible

   typedef struct {
      int          kind;   // 1 = data_valid, 2 = frame_err, 3 = sync_err
      logic [31:0] val;
      longint      cyc;
   } ev_t;

   logic   clk;
   logic   rst_n;
   longint cyc;
   longint last_start_cyc;
   int     n_vec;
   int     n_err;

   ev_t obs_q[$];
   ev_t exp_q[$];

   // reference model state
   logic        m_synced;
   logic        m_prev_lf;
   logic [7:0]  m_buf[$];
   logic [31:0] exp_data;

   uart_rx_word_if bus_if ();

   uart_rx_word #(.BPS(BPS), .BPS_2(BPS_2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   // clock generation
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // cycle counter used for latency measurement
   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      assert (got === want) else begin
         n_err++;
         $error("FAIL %s: got %h, expected %h", tag, got, want);
      end
   endtask

   // monitor: records pulses, checks exclusivity and that data moves only with data_valid
   initial begin
      logic [31:0] prev_data;
      logic        prev_rst;
      ev_t         e;
      prev_data = 32'd0;
      prev_rst  = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && prev_rst) begin
            if (bus_if.data_valid || bus_if.frame_err || bus_if.sync_err) begin
               chk("pulse_onehot", 32'($countones({bus_if.data_valid, bus_if.frame_err, bus_if.sync_err})), 32'd1);
               e.cyc = cyc;
               if (bus_if.data_valid) begin
                  e.kind = 1; e.val = bus_if.data;
               end else if (bus_if.frame_err) begin
                  e.kind = 2; e.val = 32'd0;
               end else begin
                  e.kind = 3; e.val = 32'd0;
               end
               obs_q.push_back(e);
            end
            if (bus_if.data !== prev_data) begin
               chk("data_moves_with_valid", {31'd0, bus_if.data_valid}, 32'd1);
            end
         end
         prev_data = bus_if.data;
         prev_rst  = rst_n;
      end
   end

   task automatic push_exp(input int kind, input logic [31:0] v);
      ev_t e;
      e.kind = kind; e.val = v; e.cyc = 0;
      exp_q.push_back(e);
   endtask

   task automatic model_reset();
      m_synced  = 1'b1;
      m_prev_lf = 1'b0;
      m_buf.delete();
      exp_data  = 32'd0;
   endtask

   // Byte-stream view of the protocol: in sync, collect 6 bytes and demand
   // 0A then 0D at the end; out of sync, wait for a 0A immediately followed by 0D.
   task automatic model_byte(input logic [7:0] b, input logic good);
      logic [31:0] w;
      if (!good) begin
         push_exp(2, 32'd0);
         m_synced = 1'b0; m_prev_lf = 1'b0; m_buf.delete();
      end else if (m_synced) begin
         m_buf.push_back(b);
         if (m_buf.size() == 5 && b != 8'h0A) begin
            push_exp(3, 32'd0);
            m_synced = 1'b0; m_prev_lf = 1'b0; m_buf.delete();
         end else if (m_buf.size() == 6) begin
            if (b == 8'h0D) begin
               w = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
               exp_data = w;
               push_exp(1, w);
               m_buf.delete();
            end else begin
               push_exp(3, 32'd0);
               m_synced = 1'b0; m_prev_lf = 1'b0; m_buf.delete();
            end
         end
      end else begin
         if (m_prev_lf && b == 8'h0D) begin
            m_synced = 1'b1; m_prev_lf = 1'b0; m_buf.delete();
         end else begin
            m_prev_lf = (b == 8'h0A);
         end
      end
   endtask

   // all drive tasks start and end just after a rising edge
   task automatic drive_bit(input logic v, input int per);
      bus_if.rx = v;
      repeat (per) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bus_if.rx = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic chkb, input logic stp, input int per);
      last_start_cyc = cyc;
      drive_bit(1'b0, per);
      for (int i = 0; i < 8; i++) drive_bit(b[i], per);
      drive_bit(chkb, per);
      drive_bit(stp, per);
      bus_if.rx = 1'b1;
      model_byte(b, (chkb == 1'b0) && (stp == 1'b1));
   endtask

   task automatic send_packet(input logic [31:0] w, input int per);
      send_frame(w[7:0],   1'b0, 1'b1, per);
      send_frame(w[15:8],  1'b0, 1'b1, per);
      send_frame(w[23:16], 1'b0, 1'b1, per);
      send_frame(w[31:24], 1'b0, 1'b1, per);
      send_frame(8'h0A,    1'b0, 1'b1, per);
      send_frame(8'h0D,    1'b0, 1'b1, per);
   endtask

   // compare everything observed since the last call against the model
   task automatic check_phase(input string tag);
      int n;
      repeat (5) @(posedge clk);
      #1;
      chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk({tag, "_kind"}, 32'(obs_q[i].kind), 32'(exp_q[i].kind));
         chk({tag, "_val"}, obs_q[i].val, exp_q[i].val);
      end
      obs_q.delete();
      exp_q.delete();
      chk({tag, "_data"}, bus_if.data, exp_data);
   endtask

   // directed and randomized stimulus
   initial begin
      logic [31:0] lat;
      logic [31:0] w;
      logic [7:0]  pk[6];
      int          per, corrupt, bad_idx, gap;
      logic        cb, sb;

      n_vec = 0;
      n_err = 0;
      last_start_cyc = 0;
      model_reset();

      // reset with the line held low: outputs at reset values, no start afterwards
      rst_n = 1'b0;
      bus_if.rx = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("rst_data", bus_if.data, 32'd0);
      chk("rst_valid", {31'd0, bus_if.data_valid}, 32'd0);
      chk("rst_frame_err", {31'd0, bus_if.frame_err}, 32'd0);
      chk("rst_sync_err", {31'd0, bus_if.sync_err}, 32'd0);
      rst_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      idle(4 * BIT);
      check_phase("low_at_reset");

      // nominal packet, back-to-back frames, with latency of the final pulse
      send_packet(32'h12345678, BIT);
      repeat (5) @(posedge clk);
      #1;
      lat = (obs_q.size() > 0) ? 32'(obs_q[obs_q.size() - 1].cyc - last_start_cyc) : 32'hFFFF_FFFF;
      chk("valid_latency", lat, 32'(LAT));
      check_phase("nominal");

      // sender clock +3% then -3%
      send_packet(32'hDEADBEEF, FAST);
      send_packet(32'h00000001, SLOW);
      check_phase("skew");

      // check bit set on 0x56, hunt through 0A 0D, then a good packet
      send_frame(8'h56, 1'b1, 1'b1, BIT);
      send_frame(8'h0A, 1'b0, 1'b1, BIT);
      send_frame(8'h0D, 1'b0, 1'b1, BIT);
      check_phase("frame_err");
      send_packet(32'hCAFEF00D, BIT);
      check_phase("after_frame_err");

      // bad CR trailer keeps the old word; resync and receive
      send_packet(32'h44332211, BIT);
      // replace the last model step: the packet above used 0D; resend with 0E
      check_phase("pre_sync");
      send_frame(8'h11, 1'b0, 1'b1, BIT);
      send_frame(8'h22, 1'b0, 1'b1, BIT);
      send_frame(8'h33, 1'b0, 1'b1, BIT);
      send_frame(8'h44, 1'b0, 1'b1, BIT);
      send_frame(8'h0A, 1'b0, 1'b1, BIT);
      send_frame(8'h0E, 1'b0, 1'b1, BIT);
      check_phase("sync_err");
      send_frame(8'h0A, 1'b0, 1'b1, BIT);
      send_frame(8'h0D, 1'b0, 1'b1, BIT);
      send_packet(32'hA5A5A5A5, BIT);
      check_phase("after_sync_err");

      // short low glitch on the idle line
      bus_if.rx = 1'b0;
      repeat (BPS_2 - 6) @(posedge clk);
      #1;
      idle(3 * BIT);
      check_phase("glitch");
      send_packet(32'h600DF00D, BIT);
      check_phase("after_glitch");

      // one-cycle reset during the data bits of byte 2
      send_frame(8'h0D, 1'b0, 1'b1, BIT);
      send_frame(8'hF0, 1'b0, 1'b1, BIT);
      drive_bit(1'b0, BIT);
      drive_bit(1'b1, BIT);
      drive_bit(1'b0, BIT);
      drive_bit(1'b1, BIT);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_data", bus_if.data, 32'd0);
      chk("midrst_valid", {31'd0, bus_if.data_valid}, 32'd0);
      chk("midrst_frame_err", {31'd0, bus_if.frame_err}, 32'd0);
      chk("midrst_sync_err", {31'd0, bus_if.sync_err}, 32'd0);
      rst_n = 1'b1;
      bus_if.rx = 1'b1;
      model_reset();
      obs_q.delete();
      exp_q.delete();
      idle(3 * BIT);
      send_packet(32'h0BADF00D, BIT);
      check_phase("after_reset");

      // randomized packets with skew, gaps and occasional corruption
      for (int p = 0; p < 8; p++) begin
         w       = $urandom;
         per     = FAST + int'($urandom_range(2));
         corrupt = int'($urandom_range(5));
         bad_idx = int'($urandom_range(5));
         pk[0] = w[7:0];   pk[1] = w[15:8];
         pk[2] = w[23:16]; pk[3] = w[31:24];
         pk[4] = 8'h0A;    pk[5] = 8'h0D;
         if (corrupt == 3) pk[bad_idx] = pk[bad_idx] ^ 8'h01;
         for (int i = 0; i < 6; i++) begin
            cb  = (corrupt == 1) && (i == bad_idx);
            sb  = !((corrupt == 2) && (i == bad_idx));
            gap = int'($urandom_range(4));
            send_frame(pk[i], cb, sb, per);
            if (!sb) idle(2 * BIT);
            else if (gap != 0) idle(gap);
         end
         check_phase("random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
